// File: rtl/touch_pkg.sv
// Shared types and constants for the resistive-touch SPI poller.
// Optional macro TOUCH_AVG_EN: two readings per axis, averaged.
package touch_pkg;

  typedef logic [11:0] coord_t;

  localparam logic [7:0] CMD_X = 8'hD0;
  localparam logic [7:0] CMD_Y = 8'h90;

  localparam int FRAME_BITS      = 24;
  localparam int DATA_FIRST_EDGE = 10;
  localparam int DATA_LAST_EDGE  = 21;

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_DONE} state_t;

`ifdef TOUCH_AVG_EN
  localparam int NUM_FRAMES = 4;

  // Frame order under one CS: X, X, Y, Y
  function automatic logic [7:0] frame_cmd(input logic [1:0] idx);
    return (idx < 2'd2) ? CMD_X : CMD_Y;
  endfunction
`else
  localparam int NUM_FRAMES = 2;

  function automatic logic [7:0] frame_cmd(input logic [1:0] idx);
    return (idx == 2'd0) ? CMD_X : CMD_Y;
  endfunction
`endif

endpackage

// File: rtl/touch_spi_frame.sv
// One 24-bit mode-0 SPI frame: sends the command byte, captures 12 result bits.
// A start while busy (issued on the last falling edge) chains frames seamlessly.
module touch_spi_frame
  import touch_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_cmd,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_done,
  output coord_t     o_result
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          r_busy;
  logic          r_sclk;
  logic [DW-1:0] r_div;
  logic [4:0]    r_bit;
  logic [7:0]    r_tx;
  coord_t        r_rx;

  logic w_phase_end, w_rise, w_fall, w_capture;

  assign w_phase_end = r_busy && (r_div == DIV_LAST);
  assign w_rise      = w_phase_end && !r_sclk;
  assign w_fall      = w_phase_end && r_sclk;
  assign w_capture   = w_rise && (r_bit >= 5'(DATA_FIRST_EDGE))
                              && (r_bit <= 5'(DATA_LAST_EDGE));
  assign o_done      = w_fall && (r_bit == 5'(FRAME_BITS));

  assign o_sclk   = r_sclk;
  assign o_mosi   = r_tx[7];
  assign o_result = r_rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_sclk <= 1'b0;
      r_div  <= '0;
      r_bit  <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_sclk <= 1'b0;
      r_div  <= '0;
      r_bit  <= 5'd1;
      r_tx   <= i_cmd;
    end else if (r_busy) begin
      if (w_phase_end) begin
        r_div  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_div  <= r_div + 1'b1;
      end
      if (w_capture) r_rx <= {r_rx[10:0], i_miso};
      // MOSI advances with SCLK falling; zero fill after the command byte
      if (w_fall) begin
        r_tx  <= {r_tx[6:0], 1'b0};
        r_bit <= r_bit + 1'b1;
        if (o_done) r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/touch_spi_reader.sv
// XPT2046/ADS7846 poller: periodic pen check, X/Y frames under one CS, debounce.
// Optional macro TOUCH_AVG_EN: X,X,Y,Y frames with truncating 2-sample average.
module touch_spi_reader
  import touch_pkg::*;
#(
  parameter int CLK_DIV          = 25,
  parameter int SAMPLE_PERIOD    = 500000,
  parameter int DEBOUNCE_SAMPLES = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   pen_irq_n,
  output logic   spi_cs_n,
  output logic   spi_sclk,
  output logic   spi_mosi,
  input  logic   spi_miso,
  output coord_t x_touch,
  output coord_t y_touch,
  output logic   active,
  output logic   sample_valid
);

  localparam int BUSY_SPAN = (NUM_FRAMES * 48 + 1) * CLK_DIV + 2;
  localparam int PW  = $clog2(SAMPLE_PERIOD);
  localparam int HW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DBW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [PW-1:0]  PER_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(CLK_DIV - 1);
  localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_SAMPLES);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be >= 1");
  end
  if (DEBOUNCE_SAMPLES < 1) begin : g_bad_db
    $error("DEBOUNCE_SAMPLES must be >= 1");
  end
  if (SAMPLE_PERIOD <= BUSY_SPAN) begin : g_bad_period
    $error("SAMPLE_PERIOD too short: a tick could land mid-sample");
  end

  state_t         r_state, w_next;
  logic [PW-1:0]  r_period;
  logic [HW-1:0]  r_hold;
  logic [DBW-1:0] r_db_cnt, w_db_next;
  logic [1:0]     r_idx;
  logic [12:0]    r_x_sum, r_y_sum;
  logic           r_pen_meta, r_pen_sync;
  logic           r_cs_n;
  coord_t         r_x_touch, r_y_touch;
  logic           r_active, r_sample_valid;

  logic       w_tick, w_pen_dn, w_start, w_frame_done;
  logic [7:0] w_cmd;
  coord_t     w_result;

  assign w_tick    = (r_period == PER_LAST);
  assign w_pen_dn  = ~r_pen_sync;
  assign w_db_next = (r_db_cnt == DB_MAX) ? r_db_cnt : r_db_cnt + 1'b1;

  assign spi_cs_n     = r_cs_n;
  assign x_touch      = r_x_touch;
  assign y_touch      = r_y_touch;
  assign active       = r_active;
  assign sample_valid = r_sample_valid;

  touch_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_cmd    (w_cmd),
    .i_miso   (spi_miso),
    .o_sclk   (spi_sclk),
    .o_mosi   (spi_mosi),
    .o_done   (w_frame_done),
    .o_result (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_cmd   = CMD_X;
    case (r_state)
      ST_IDLE: if (w_tick && w_pen_dn) begin
        w_next  = ST_FRAME;
        w_start = 1'b1;
        w_cmd   = frame_cmd(2'd0);
      end
      ST_FRAME: if (w_frame_done) begin
        if (r_idx == 2'(NUM_FRAMES - 1)) begin
          w_next = ST_DONE;
        end else begin
          // next frame starts on this falling edge so CS never gaps
          w_start = 1'b1;
          w_cmd   = frame_cmd(r_idx + 2'd1);
        end
      end
      ST_DONE: if (r_hold == HOLD_LAST) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period       <= '0;
      r_hold         <= '0;
      r_db_cnt       <= '0;
      r_idx          <= '0;
      r_x_sum        <= '0;
      r_y_sum        <= '0;
      r_pen_meta     <= 1'b1;
      r_pen_sync     <= 1'b1;
      r_cs_n         <= 1'b1;
      r_x_touch      <= '0;
      r_y_touch      <= '0;
      r_active       <= 1'b0;
      r_sample_valid <= 1'b0;
    end else begin
      r_period       <= w_tick ? '0 : r_period + 1'b1;
      r_pen_meta     <= pen_irq_n;
      r_pen_sync     <= r_pen_meta;
      r_sample_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_tick) begin
          if (w_pen_dn) begin
            r_cs_n <= 1'b0;
            r_idx  <= '0;
          end else begin
            r_db_cnt <= '0;
            r_active <= 1'b0;
          end
        end
        ST_FRAME: if (w_frame_done) begin
          r_idx  <= r_idx + 2'd1;
          r_hold <= '0;
`ifdef TOUCH_AVG_EN
          case (r_idx)
            2'd0:    r_x_sum <= {1'b0, w_result};
            2'd1:    r_x_sum <= r_x_sum + {1'b0, w_result};
            2'd2:    r_y_sum <= {1'b0, w_result};
            default: r_y_sum <= r_y_sum + {1'b0, w_result};
          endcase
`else
          // stored pre-doubled so both builds publish sum[12:1]
          if (r_idx[0]) r_y_sum <= {w_result, 1'b0};
          else          r_x_sum <= {w_result, 1'b0};
`endif
        end
        ST_DONE: begin
          if (r_hold == HOLD_LAST) begin
            r_cs_n   <= 1'b1;
            r_db_cnt <= w_db_next;
            if (w_db_next == DB_MAX) begin
              r_x_touch      <= r_x_sum[12:1];
              r_y_touch      <= r_y_sum[12:1];
              r_sample_valid <= 1'b1;
              r_active       <= 1'b1;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_touch_spi_reader.sv
// Scoreboarded bench for touch_spi_reader with a behavioural XPT2046 model.
// Honours TOUCH_AVG_EN when compiled with it.
module tb_touch_spi_reader;

  localparam int CD = 2;
  localparam int SP = 400;
`ifdef TOUCH_AVG_EN
  localparam int NF      = 4;
  localparam int CS_LEN  = 386;
  localparam int RISES   = 96;
`else
  localparam int NF      = 2;
  localparam int CS_LEN  = 194;
  localparam int RISES   = 48;
`endif

  typedef struct packed { logic [11:0] x; logic [11:0] y; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic pen_irq_n;
  logic spi_cs_n, spi_sclk, spi_mosi;
  logic spi_miso = 1'b0;
  logic [11:0] x_touch, y_touch;
  logic active, sample_valid;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  touch_spi_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .DEBOUNCE_SAMPLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pen_irq_n    (pen_irq_n),
    .spi_cs_n     (spi_cs_n),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .x_touch      (x_touch),
    .y_touch      (y_touch),
    .active       (active),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SPI slave model and bus monitor ----------------
  logic [11:0] word [4];
  logic [7:0]  mbyte [4];
  int cs_cnt = 0, rise_cnt = 0, unstable = 0, nonzero = 0;
  int windows = 0, idle_edges = 0, last_len = 0, last_rise = 0, cs_fall_cyc = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

  always @(negedge clk) begin
    int pos, fr, e;
    if (!spi_cs_n) begin
      if (prev_cs) begin
        cs_cnt = 0; rise_cnt = 0; unstable = 0; nonzero = 0;
        for (int i = 0; i < 4; i++) mbyte[i] = 8'h00;
        cs_fall_cyc = cyc;
      end
      cs_cnt++;
      if (!prev_sclk && spi_sclk) begin
        rise_cnt++;
        if (spi_mosi !== prev_mosi) unstable++;
        pos = ((rise_cnt - 1) % 24) + 1;
        fr  = (rise_cnt - 1) / 24;
        if (fr < 4) begin
          if (pos <= 8) mbyte[fr] = {mbyte[fr][6:0], spi_mosi};
          else if (spi_mosi !== 1'b0) nonzero++;
        end
      end
      // present the bit for the next rising edge; non-data slots read as 1
      e   = rise_cnt + 1;
      pos = ((e - 1) % 24) + 1;
      fr  = (e - 1) / 24;
      if (fr < 4 && pos >= 10 && pos <= 21) spi_miso = word[fr][21 - pos];
      else spi_miso = 1'b1;
    end else begin
      if (!prev_cs) begin
        last_len  = cs_cnt;
        last_rise = rise_cnt;
        windows++;
      end
      if (!prev_sclk && spi_sclk) idle_edges++;
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
    prev_mosi = spi_mosi;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sv_x_touch", 32'(x_touch), 32'(e.x));
        chk("sv_y_touch", 32'(y_touch), 32'(e.y));
        chk("sv_active", 32'(active), 32'd1);
      end
    end
  end

  task automatic wait_windows(input int target, input string name);
    int n = 0;
    while (windows < target && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (windows < target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, windows %0d expected %0d", name, windows, target);
    end
    @(negedge clk);
  endtask

  task automatic check_window(input string tag);
    chk({tag, "_cs_len"}, 32'(last_len), 32'(CS_LEN));
    chk({tag, "_rises"}, 32'(last_rise), 32'(RISES));
    chk({tag, "_mosi_unstable"}, 32'(unstable), 32'd0);
    chk({tag, "_mosi_tail_nonzero"}, 32'(nonzero), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, p, n;
    exp_t ex;
    logic [7:0] exp_cmd [4];
`ifdef TOUCH_AVG_EN
    exp_cmd[0] = 8'hD0; exp_cmd[1] = 8'hD0; exp_cmd[2] = 8'h90; exp_cmd[3] = 8'h90;
`else
    exp_cmd[0] = 8'hD0; exp_cmd[1] = 8'h90; exp_cmd[2] = 8'h00; exp_cmd[3] = 8'h00;
`endif
    for (int i = 0; i < 4; i++) word[i] = 12'h000;

    // reset state
    rst_n = 1'b0;
    pen_irq_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_x", 32'(x_touch), 32'd0);
    chk("rst_y", 32'(y_touch), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    rst_n = 1'b1;

    // pen up across three ticks
    repeat (3 * SP + 20) @(negedge clk);
    chk("idle_sclk_edges", 32'(idle_edges), 32'd0);
    chk("idle_cs_windows", 32'(windows), 32'd0);
    chk("idle_active", 32'(active), 32'd0);

    // pen down: first sample debounces, second publishes
`ifdef TOUCH_AVG_EN
    word[0] = 12'h100; word[1] = 12'h103; word[2] = 12'h3F0; word[3] = 12'h3F3;
    ex.x = 12'h101; ex.y = 12'h3F1;
`else
    word[0] = 12'hA5C; word[1] = 12'h3F1;
    ex.x = 12'hA5C; ex.y = 12'h3F1;
`endif
    pen_irq_n = 1'b0;
    w0 = windows;
    wait_windows(w0 + 1, "first_sample");
    chk("first_sample_active", 32'(active), 32'd0);
    check_window("w1");
    for (int i = 0; i < NF; i++) chk("w1_mosi_cmd", 32'(mbyte[i]), 32'(exp_cmd[i]));
    exp_q.push_back(ex);
    wait_windows(w0 + 2, "second_sample");
    chk("second_sample_consumed", 32'(exp_q.size()), 32'd0);
    chk("second_active", 32'(active), 32'd1);
    chk("second_x", 32'(x_touch), 32'(ex.x));
    chk("second_y", 32'(y_touch), 32'(ex.y));
    check_window("w2");

    // pen released before next tick
    p = cs_fall_cyc;
    pen_irq_n = 1'b1;
    while (cyc < p + SP - 1) @(negedge clk);
    chk("release_active_before_tick", 32'(active), 32'd1);
    @(negedge clk);
    chk("release_active_after_tick", 32'(active), 32'd0);
    repeat (450) @(negedge clk);
    chk("release_no_cs", 32'(windows), 32'(w0 + 2));
    chk("release_x_hold", 32'(x_touch), 32'(ex.x));
    chk("release_y_hold", 32'(y_touch), 32'(ex.y));

    // reset asserted mid-frame during SCLK bit 30
`ifdef TOUCH_AVG_EN
    word[0] = 12'h801; word[1] = 12'h7FF; word[2] = 12'hFFF; word[3] = 12'hFFE;
    ex.x = 12'h800; ex.y = 12'hFFE;
`else
    word[0] = 12'h801; word[1] = 12'hFFF;
    ex.x = 12'h801; ex.y = 12'hFFF;
`endif
    pen_irq_n = 1'b0;
    n = 0;
    while (!(spi_cs_n === 1'b0 && rise_cnt == 30 && spi_sclk === 1'b1) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit30", 32'(n < 1500), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("midrst_sclk", 32'(spi_sclk), 32'd0);
    chk("midrst_x", 32'(x_touch), 32'd0);
    chk("midrst_active", 32'(active), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = windows;
    wait_windows(w0 + 1, "post_rst_first");
    chk("post_rst_first_active", 32'(active), 32'd0);
    check_window("w3");
    exp_q.push_back(ex);
    wait_windows(w0 + 2, "post_rst_second");
    chk("post_rst_consumed", 32'(exp_q.size()), 32'd0);
    chk("post_rst_active", 32'(active), 32'd1);
    chk("post_rst_x", 32'(x_touch), 32'(ex.x));
    chk("post_rst_y", 32'(y_touch), 32'(ex.y));

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/touch_spi_reader.md
Name: touch_spi_reader

Overview:
- SPI master that polls a resistive-touch controller (XPT2046/ADS7846 command set) and produces the `x_touch`/`y_touch`/`active` triple consumed by the per-square hit-test blocks.
- Periodically checks the pen-down line. While the pen is down, runs an X conversion frame then a Y conversion frame, debounces, and publishes the coordinates with a one-cycle `sample_valid` strobe.
- Sits between the board touch-controller pins and the cube-face input logic.

Parameters:
- CLK_DIV, 25: clk cycles per SCLK half-period; must be ≥1.
- SAMPLE_PERIOD, 500000: clk cycles between sample ticks.
- DEBOUNCE_SAMPLES, 2: consecutive pen-down samples needed before `active` rises; must be ≥1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pen_irq_n  input  1  controller PENIRQ, asynchronous, low = pen down
- spi_cs_n  output  1  chip select, active low
- spi_sclk  output  1  SPI clock, mode 0, idles low
- spi_mosi  output  1  command data to controller
- spi_miso  input  1  conversion data from controller
- x_touch  output  12  last published X coordinate
- y_touch  output  12  last published Y coordinate
- active  output  1  debounced touch present
- sample_valid  output  1  one-cycle strobe when x_touch/y_touch update

Behaviour:
- Reset: asynchronous, active-low, one clock.
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0.
  - x_touch=0, y_touch=0, active=0, sample_valid=0.
  - Debounce count=0, period counter=0, FSM=IDLE.
- pen_irq_n passes through a 2-flop synchroniser to give pen_dn. pen_dn is evaluated only at the sample tick, never mid-frame.
- The period counter is free-running and emits a tick every SAMPLE_PERIOD cycles.
  - Elaboration assertion: SAMPLE_PERIOD > 97*CLK_DIV+2 (193*CLK_DIV+2 with TOUCH_AVG_EN), so a tick never arrives while busy.
  - A tick that arrives outside IDLE is ignored.
- FSM states: IDLE, FRAME, DONE.
  - IDLE, tick with pen_dn=0: stay in IDLE; no SPI activity; debounce count cleared; active=0 in the next cycle; x/y hold.
  - IDLE, tick with pen_dn=1: spi_cs_n falls in the next cycle (call this t0); go to FRAME.
  - FRAME: 48 SCLK periods with CS held low throughout (X frame bits 1-24, then Y frame bits 25-48).
    - Rising edge k occurs at t0+(2k-1)*CLK_DIV; falling edge k at t0+2k*CLK_DIV.
    - MOSI changes only while SCLK is low. Bit 1 is valid from t0.
    - MOSI carries 0xD0 (X, 12-bit, differential) in frame bits 1-8, 0 for bits 9-24. The Y frame does the same with 0x90.
    - MISO is sampled on rising edges 10..21 of each frame, MSB first, into a 12-bit result. All other edges are ignored.
  - DONE, entered at falling edge 48:
    - spi_cs_n rises at t0+97*CLK_DIV (2425 cycles for the default CLK_DIV).
    - In that same cycle, debounce count increments, saturating at DEBOUNCE_SAMPLES.
    - If the count equals DEBOUNCE_SAMPLES: x_touch/y_touch load the results, sample_valid=1 for one cycle, active=1.
    - Otherwise the results are discarded.
    - Return to IDLE.
- The pen lifting mid-frame does not abort the frame. The next tick handles it.
- Reset asserted mid-frame: outputs go to reset values immediately (CS released asynchronously, SCLK low). After release, debounce restarts from 0.
- Arithmetic: results are unsigned 12-bit. No offset or scaling is applied.

Optional Feature:
- Macro: TOUCH_AVG_EN.
- Defined:
  - Each sample runs 4 frames under one CS: X, X, Y, Y (96 SCLK periods). CS rises at t0+193*CLK_DIV.
  - Each output is a 13-bit sum of the two readings for that axis, bits [12:1] (truncating average).
- Undefined: single X and single Y frame as described above.
- All other behaviour is identical with or without the macro.

Decomposition:
- Package touch_pkg holds:
  - typedef coord_t (logic [11:0]);
  - CMD_X=8'hD0, CMD_Y=8'h90;
  - FRAME_BITS=24, DATA_FIRST_EDGE=10, DATA_LAST_EDGE=21;
  - FSM state enum.
- One sub-module, touch_spi_frame, runs one 24-bit frame given a command byte. It generates SCLK from CLK_DIV, drives MOSI and captures the 12-bit result. It returns frame_done on falling edge 24.
- The top level owns CS, sequencing, the period timer, debounce and the output registers.

Test Plan:
All scenarios use CLK_DIV=2, SAMPLE_PERIOD=400, DEBOUNCE_SAMPLES=2.
- Reset → spi_cs_n=1, spi_sclk=0, x/y=0, active=0, sample_valid=0; no SCLK edges while pen_irq_n=1 across 3 ticks.
- pen_irq_n=0, MISO model returns X=0xA5C, Y=0x3F1:
  - 1st tick: no sample_valid, active=0.
  - 2nd tick: sample_valid pulses once; x_touch=0xA5C, y_touch=0x3F1, active=1.
  - MOSI bytes decode to 0xD0 then 0x90.
- Frame timing: spi_cs_n low for exactly 194 cycles; exactly 48 rising SCLK edges; MOSI stable at every rising edge.
- Pen released (pen_irq_n=1) before the next tick → no CS activity, active=0 one cycle after the tick, x/y hold 0xA5C/0x3F1, no sample_valid.
- rst_n low during SCLK bit 30 → spi_cs_n=1 and spi_sclk=0 in the same cycle. After release with pen down, the first tick gives no sample_valid and the second tick gives it.
- TOUCH_AVG_EN, X readings 0x100 then 0x103 → x_touch=0x101; spi_cs_n low for 386 cycles; 96 SCLK edges.
